// File: rtl/game_turn_ctrl.sv
// Phase sequencer for the 5x5 battleship game: ship placement, PC placement,
// alternating shot turns with a per-turn countdown, and game over.
module game_turn_ctrl #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TURN_SECS = 15,
    parameter int MAX_SHIPS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] shipQ,
    input  logic       placed,
    output logic       place_en,
    output logic [2:0] place_size,
    output logic       pc_place_en,
    input  logic       pc_place_done,
    input  logic       fire,
    output logic       shot_en,
    output logic       pc_fire_en,
    input  logic       pc_fire_done,
    input  logic       pc_sunk_all,
    input  logic       pl_sunk_all,
    output logic [2:0] state,
    output logic [3:0] turn_secs,
    output logic       win,
    output logic       lose
);

    localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);
    localparam logic [3:0] SECS_INIT = 4'(TURN_SECS);
    localparam logic [2:0] SHIPS_MAX = 3'(MAX_SHIPS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PLACE    = 3'd1,
        S_PC_PLACE = 3'd2,
        S_P_TURN   = 3'd3,
        S_P_CHECK  = 3'd4,
        S_PC_TURN  = 3'd5,
        S_PC_CHECK = 3'd6,
        S_OVER     = 3'd7
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    logic [2:0]        nships;
    logic [2:0]        shipq_clamped;
    logic [TICK_W-1:0] tick;
    logic [3:0]        secs;
    logic              tick_wrap;
    logic              timeout;
    logic              shot;
    logic              last_ship;

    // Handshake: every *_done, placed, fire and start input is a 1-cycle pulse,
    // acted on only in the state that owns it; enables are levels held until the
    // matching done pulse moves the FSM on.
    always_comb begin
        shipq_clamped = shipQ;
        if (shipQ == 3'd0) begin
            shipq_clamped = 3'd1;
        end else if (shipQ > SHIPS_MAX) begin
            shipq_clamped = SHIPS_MAX;
        end
    end

    assign tick_wrap = (cur_state == S_P_TURN) && (tick == TICK_LAST);
    assign timeout   = tick_wrap && (secs == 4'd1);
    // fire and timeout in the same cycle collapse into one shot
    assign shot      = (cur_state == S_P_TURN) && (fire || timeout);
    assign last_ship = (place_size == nships);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE:     if (start) nxt_state = S_PLACE;
            S_PLACE:    if (placed && last_ship) nxt_state = S_PC_PLACE;
            S_PC_PLACE: if (pc_place_done) nxt_state = S_P_TURN;
            S_P_TURN:   if (shot) nxt_state = S_P_CHECK;
            S_P_CHECK:  nxt_state = pc_sunk_all ? S_OVER : S_PC_TURN;
            S_PC_TURN:  if (pc_fire_done) nxt_state = S_PC_CHECK;
            S_PC_CHECK: nxt_state = pl_sunk_all ? S_OVER : S_P_TURN;
            S_OVER:     if (start) nxt_state = S_IDLE;
            default:    nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        place_en    = (cur_state == S_PLACE);
        pc_place_en = (cur_state == S_PC_PLACE);
        pc_fire_en  = (cur_state == S_PC_TURN);
        shot_en     = shot;
        state       = cur_state;
        turn_secs   = secs;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nships     <= 3'd0;
            place_size <= 3'd0;
        end else if (cur_state == S_IDLE && start) begin
            nships     <= shipq_clamped;
            place_size <= 3'd1;
        end else if (cur_state == S_PLACE && placed && !last_ship) begin
            place_size <= place_size + 3'd1;
        end
    end

    // The timer reloads on every entry to P_TURN and reads 0 everywhere else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick <= '0;
            secs <= 4'd0;
        end else if (nxt_state == S_P_TURN && cur_state != S_P_TURN) begin
            tick <= '0;
            secs <= SECS_INIT;
        end else if (nxt_state == S_P_TURN) begin
            if (tick_wrap) begin
                tick <= '0;
                secs <= secs - 4'd1;
            end else begin
                tick <= tick + TICK_W'(1);
            end
        end else begin
            tick <= '0;
            secs <= 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win  <= 1'b0;
            lose <= 1'b0;
        end else if (cur_state == S_OVER && start) begin
            win  <= 1'b0;
            lose <= 1'b0;
        end else if (cur_state == S_P_CHECK && pc_sunk_all) begin
            win <= 1'b1;
        end else if (cur_state == S_PC_CHECK && pl_sunk_all) begin
            lose <= 1'b1;
        end
    end

endmodule
